// File: rtl/ray_stream_generator_pkg.sv
// Shared fixed-point types, screen defaults and FSM encoding for the ray stream generator.
package ray_stream_generator_pkg;

    // Q8.24 signed fixed point
    localparam int FRAC_BITS = 24;
    typedef logic signed [31:0] fp;
    typedef fp [2:0] vec3;              // [0]=x, [1]=y, [2]=z
    localparam fp FP_ONE = 32'sh0100_0000;

    // Default frame geometry
    localparam int DEFAULT_WIDTH  = 640;
    localparam int DEFAULT_HEIGHT = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Setup steps 0..14 are multiplies; step 15 loads the accumulators
    localparam logic [3:0] SETUP_LAST = 4'd15;

    // Full-precision signed product, arithmetic shift floors toward -inf
    function automatic fp fp_mul(input fp a, input fp b);
        logic signed [63:0] prod;
        prod = 64'(a) * 64'(b);
        return fp'(prod >>> FRAC_BITS);
    endfunction

endpackage

// File: rtl/ray_stream_generator_if.sv
// Ray beat stream: valid/ready handshake carrying direction, pixel coordinates and markers.
interface ray_stream_generator_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    import ray_stream_generator_pkg::*;

    logic           out_valid;
    logic           out_ready;
    vec3            ray_direction;
    logic [X_W-1:0] pixel_x;
    logic [Y_W-1:0] pixel_y;
    logic           sof;
    logic           eol;
    logic           eof;

    modport master (
        output out_valid, ray_direction, pixel_x, pixel_y, sof, eol, eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, ray_direction, pixel_x, pixel_y, sof, eol, eof,
        output out_ready
    );

endinterface

// File: rtl/ray_stream_generator_fixed_mul_q824.sv
// Combinational Q8.24 x Q8.24 multiply; the single multiplier shared across setup steps.
module fixed_mul_q824
    import ray_stream_generator_pkg::*;
(
    input  fp a,
    input  fp b,
    output fp p
);

    assign p = fp_mul(a, b);

endmodule

// File: rtl/ray_stream_generator.sv
// Streams one primary-ray direction per pixel in raster order after a 16-cycle camera setup.
// Setup derives per-column/per-row steps once so the run phase only adds and subtracts.
module ray_stream_generator
    import ray_stream_generator_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEFAULT_WIDTH,
    parameter int SCREEN_HEIGHT = DEFAULT_HEIGHT,
    parameter int X_W           = $clog2(SCREEN_WIDTH),
    parameter int Y_W           = $clog2(SCREEN_HEIGHT)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  vec3  camera_forward,
    input  vec3  camera_right,
    input  vec3  camera_up,
    input  fp    tan_half_fov,
    output logic busy,
    output logic frame_done,
    ray_stream_generator_if.master ray_out
);

    localparam fp STEP_X = fp'((64'(2) << FRAC_BITS) / 64'(SCREEN_WIDTH));
    localparam fp STEP_Y = fp'((64'(2) << FRAC_BITS) / 64'(SCREEN_HEIGHT));
    localparam fp ASPECT = fp'((64'(SCREEN_WIDTH) << FRAC_BITS) / 64'(SCREEN_HEIGHT));

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_HEIGHT - 1);

    state_t         state, state_nx;
    logic [3:0]     cnt;
    fp              tan_r, ta, sx, sy, ox, oy;
    vec3            right_r, up_r;
    vec3            step_r, step_u;
    vec3            origin, row_acc, cur;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    fp              mul_a, mul_b, mul_p;
    logic [1:0]     sel_c;
    logic           fire, last_col, last_row;

    // Half-step offsets come straight off the adder, never through the multiplier
    assign ox = ta - (sx >>> 1);
    assign oy = tan_r - (sy >>> 1);

    assign fire     = (state == ST_RUN) && ray_out.out_ready;
    assign last_col = (x == X_LAST);
    assign last_row = (y == Y_LAST);

    assign busy                  = (state != ST_IDLE);
    assign ray_out.out_valid     = (state == ST_RUN);
    assign ray_out.ray_direction = cur;
    assign ray_out.pixel_x       = x;
    assign ray_out.pixel_y       = y;
    assign ray_out.sof           = ray_out.out_valid && (x == '0) && (y == '0);
    assign ray_out.eol           = ray_out.out_valid && last_col;
    assign ray_out.eof           = ray_out.out_valid && last_col && last_row;
    // An aborted frame never reports completion, even if its last beat lands in the abort cycle
    assign frame_done            = fire && last_col && last_row && !abort;

    fixed_mul_q824 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Select the vector component the current setup step works on
    always_comb begin
        sel_c = 2'd0;
        if (cnt >= 4'd9)      sel_c = 2'((cnt - 4'd9) >> 1);
        else if (cnt >= 4'd6) sel_c = 2'(cnt - 4'd6);
        else if (cnt >= 4'd3) sel_c = 2'(cnt - 4'd3);
    end

    // Multiplier operand schedule, one product per setup step
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (cnt)
            4'd0:                begin mul_a = tan_r;          mul_b = ASPECT; end
            4'd1:                begin mul_a = ta;             mul_b = STEP_X; end
            4'd2:                begin mul_a = tan_r;          mul_b = STEP_Y; end
            4'd3, 4'd4, 4'd5:    begin mul_a = right_r[sel_c]; mul_b = sx;     end
            4'd6, 4'd7, 4'd8:    begin mul_a = up_r[sel_c];    mul_b = sy;     end
            4'd9, 4'd11, 4'd13:  begin mul_a = right_r[sel_c]; mul_b = ox;     end
            4'd10, 4'd12, 4'd14: begin mul_a = up_r[sel_c];    mul_b = oy;     end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state; abort overrides every transition
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_SETUP;
            ST_SETUP: if (cnt == SETUP_LAST) state_nx = ST_RUN;
            ST_RUN:   if (fire && last_col && last_row) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (abort) state_nx = ST_IDLE;
    end

    // Camera latch, setup arithmetic and raster accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            tan_r   <= '0;
            right_r <= '0;
            up_r    <= '0;
            ta      <= '0;
            sx      <= '0;
            sy      <= '0;
            step_r  <= '0;
            step_u  <= '0;
            origin  <= '0;
            row_acc <= '0;
            cur     <= '0;
            x       <= '0;
            y       <= '0;
        end else if (abort) begin
            cnt <= '0;
            x   <= '0;
            y   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    tan_r   <= tan_half_fov;
                    right_r <= camera_right;
                    up_r    <= camera_up;
                    origin  <= camera_forward;   // origin accumulates on top of forward
                    cnt     <= '0;
                    x       <= '0;
                    y       <= '0;
                end
                ST_SETUP: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd0)       ta <= mul_p;
                    else if (cnt == 4'd1)  sx <= mul_p;
                    else if (cnt == 4'd2)  sy <= mul_p;
                    else if (cnt <= 4'd5)  step_r[sel_c] <= mul_p;
                    else if (cnt <= 4'd8)  step_u[sel_c] <= mul_p;
                    else if (cnt <= 4'd14) begin
                        // odd steps remove the right offset, even steps add the up offset
                        if (cnt[0]) origin[sel_c] <= origin[sel_c] - mul_p;
                        else        origin[sel_c] <= origin[sel_c] + mul_p;
                    end else begin
                        row_acc <= origin;
                        cur     <= origin;
                    end
                end
                ST_RUN: if (ray_out.out_ready) begin
                    if (last_col && last_row) begin
                        x <= '0;
                        y <= '0;
                    end else if (!last_col) begin
                        for (int c = 0; c < 3; c++) cur[c] <= cur[c] + step_r[c];
                        x <= x + 1'b1;
                    end else begin
                        for (int c = 0; c < 3; c++) begin
                            row_acc[c] <= row_acc[c] - step_u[c];
                            cur[c]     <= row_acc[c] - step_u[c];
                        end
                        x <= '0;
                        y <= y + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_stream_generator.sv
// Scoreboard bench: expected beats are queued at frame start and popped as the DUT delivers them.
module tb_ray_stream_generator;
    import ray_stream_generator_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct packed {
        vec3        dir;
        logic [1:0] x;
        logic [1:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    logic clk = 1'b0;
    logic rst, start, abort, start8;
    vec3  fwd, rgt, upv;
    fp    tanv;
    logic busy, frame_done, busy8, frame_done8;

    beat_t exp_q[$];
    beat_t act_b, exp_b;
    logic  exp_fd;
    int    n_vec = 0;
    int    n_err = 0;
    int    acc_cnt = 0;
    int    fd_cnt = 0;
    bit    mon_en = 1'b0;
    fp     x0;

    ray_stream_generator_if #(.X_W(2), .Y_W(2)) rs ();
    ray_stream_generator_if #(.X_W(3), .Y_W(2)) rs8 ();

    ray_stream_generator #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .camera_forward(fwd), .camera_right(rgt), .camera_up(upv), .tan_half_fov(tanv),
        .busy(busy), .frame_done(frame_done), .ray_out(rs)
    );

    ray_stream_generator #(.SCREEN_WIDTH(8), .SCREEN_HEIGHT(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(1'b0),
        .camera_forward(fwd), .camera_right(rgt), .camera_up(upv), .tan_half_fov(tanv),
        .busy(busy8), .frame_done(frame_done8), .ray_out(rs8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected raster: dir = origin + x*step_right - y*step_up
    task automatic push_frame(input vec3 org, input vec3 sr, input vec3 su);
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                beat_t b;
                for (int c = 0; c < 3; c++) b.dir[c] = org[c] + fp'(xx) * sr[c] - fp'(yy) * su[c];
                b.x   = 2'(xx);
                b.y   = 2'(yy);
                b.sof = (xx == 0) && (yy == 0);
                b.eol = (xx == W - 1);
                b.eof = (xx == W - 1) && (yy == H - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k;
        k = 0;
        while (acc_cnt < n && k < budget) begin
            tick();
            k++;
        end
        chk("beats_reached", acc_cnt, n);
    endtask

    // Start pulse plus first-beat latency: valid must be low after edge 15, high after edge 16
    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", busy, 1'b1);
        repeat (15) tick();
        chk("lat15_invalid", rs.out_valid, 1'b0);
        tick();
        chk("lat16_valid", rs.out_valid, 1'b1);
    endtask

    task automatic std_camera();
        fwd  = {32'hFF00_0000, 32'h0, 32'h0};
        rgt  = {32'h0, 32'h0, FP_ONE};
        upv  = {32'h0, FP_ONE, 32'h0};
        tanv = FP_ONE;
    endtask

    task automatic push_std();
        push_frame({32'hFF00_0000, 32'h00C0_0000, 32'hFF40_0000},
                   {32'h0, 32'h0, 32'h0080_0000},
                   {32'h0, 32'h0080_0000, 32'h0});
    endtask

    // Compare every presented beat against the queue head; pop only on acceptance
    always @(negedge clk) begin
        if (mon_en) begin
            exp_fd = 1'b0;
            if (rs.out_valid) begin
                act_b = '{dir: rs.ray_direction, x: rs.pixel_x, y: rs.pixel_y,
                          sof: rs.sof, eol: rs.eol, eof: rs.eof};
                chk("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q[0];
                    chk("beat", act_b, exp_b);
                    if (rs.out_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                        exp_fd = exp_b.eof && !abort;
                    end
                end
            end
            if (rs.out_valid || frame_done) chk("frame_done", frame_done, exp_fd);
            if (frame_done) fd_cnt++;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start8 = 1'b0;
        rs.out_ready = 1'b0; rs8.out_ready = 1'b1;
        std_camera();
        repeat (3) tick();
        chk("rst_valid", rs.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_outs", {rs.ray_direction, rs.pixel_x, rs.pixel_y, rs.sof, rs.eol, rs.eof, frame_done}, '0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Frame with ready held high
        push_std();
        rs.out_ready = 1'b1;
        start_frame();
        wait_acc(16, 100);
        chk("frame_idle_busy", busy, 1'b0);
        chk("frame_idle_valid", rs.out_valid, 1'b0);
        chk("frame_done_count", fd_cnt, 1);
        chk("queue_drained", exp_q.size(), 0);

        // Backpressure: same sequence under random ready
        acc_cnt = 0; fd_cnt = 0;
        push_std();
        start_frame();
        for (int k = 0; k < 400 && acc_cnt < 16; k++) begin
            rs.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("bp_beats", acc_cnt, 16);
        rs.out_ready = 1'b1;
        tick();
        chk("bp_busy", busy, 1'b0);
        chk("bp_frame_done_count", fd_cnt, 1);

        // Permuted basis, narrower field of view
        acc_cnt = 0; fd_cnt = 0;
        fwd  = {32'h0, 32'h0, FP_ONE};
        rgt  = {FP_ONE, 32'h0, 32'h0};
        upv  = {32'h0, FP_ONE, 32'h0};
        tanv = 32'h0080_0000;
        push_frame({32'hFFA0_0000, 32'h0060_0000, 32'h0100_0000},
                   {32'h0040_0000, 32'h0, 32'h0},
                   {32'h0, 32'h0040_0000, 32'h0});
        start_frame();
        std_camera();            // inputs are latched, changing them now must not matter
        wait_acc(16, 100);
        chk("perm_frame_done_count", fd_cnt, 1);

        // Abort on the sixth accepted beat, then restart cleanly
        acc_cnt = 0; fd_cnt = 0;
        push_std();
        start_frame();
        wait_acc(5, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", rs.out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_delivered", acc_cnt, 6);
        tick();
        chk("abort_no_done", fd_cnt, 0);
        exp_q.delete();
        acc_cnt = 0;
        push_std();
        start_frame();
        wait_acc(16, 100);
        chk("restart_done_count", fd_cnt, 1);

        // start during SETUP and RUN is ignored
        acc_cnt = 0; fd_cnt = 0;
        push_std();
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_acc(4, 100);
        start = 1'b1; tick(); start = 1'b0;
        wait_acc(16, 100);
        repeat (20) tick();
        chk("no_restart_beats", acc_cnt, 16);
        chk("no_restart_busy", busy, 1'b0);

        // Reset in the middle of a frame
        acc_cnt = 0;
        push_std();
        start_frame();
        wait_acc(3, 100);
        rst = 1'b1;
        tick();
        chk("midrst_valid", rs.out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_outs", {rs.ray_direction, rs.pixel_x, rs.pixel_y, rs.sof, rs.eol, rs.eof, frame_done}, '0);
        rst = 1'b0;
        exp_q.delete();
        tick();

        // 8x4 frame: aspect ratio 2
        std_camera();
        start8 = 1'b1; tick(); start8 = 1'b0;
        repeat (15) tick();
        chk("w8_lat15_invalid", rs8.out_valid, 1'b0);
        tick();
        chk("w8_lat16_valid", rs8.out_valid, 1'b1);
        chk("w8_dir_x", $unsigned(rs8.ray_direction[0]), 32'hFE40_0000);
        chk("w8_dir_y", $unsigned(rs8.ray_direction[1]), 32'h00C0_0000);
        chk("w8_dir_z", $unsigned(rs8.ray_direction[2]), 32'hFF00_0000);
        chk("w8_first_pix", {rs8.pixel_x, rs8.pixel_y, rs8.sof}, {3'd0, 2'd0, 1'b1});
        x0 = rs8.ray_direction[0];
        tick();
        chk("w8_dir_x1", $unsigned(rs8.ray_direction[0]), 32'hFEC0_0000);
        chk("w8_step_x", $unsigned(rs8.ray_direction[0] - x0), 32'h0080_0000);
        chk("w8_pix1", rs8.pixel_x, 3'd1);
        repeat (40) tick();
        chk("w8_idle", busy8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
